// File: rtl/tsc_pkg.sv
// tsc_pkg: shared types and constants for the transient capture block.
package tsc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE,
        S_SEND
    } state_t;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_ANY  = 2'b10;

    // pa/sa: previous and current sample are at or above threshold
    function automatic logic edge_hit(
        input logic [1:0] mode,
        input logic       pa,
        input logic       sa
    );
        logic r;
        logic f;
        r = !pa && sa;
        f = pa && !sa;
        case (mode)
            EDGE_FALL: return f;
            EDGE_ANY:  return r || f;
            default:   return r;
        endcase
    endfunction

endpackage

// File: rtl/tsc_pretrig_capture_if.sv
// tsc_pretrig_capture_if: readout stream of the capture block,
// valid/ready with data held while stalled.
interface tsc_pretrig_capture_if #(
    parameter int DW = 8
);
    logic [DW-1:0] sd_data;
    logic          sd_valid;
    logic          sd_ready;

    modport master (
        output sd_data,
        output sd_valid,
        input  sd_ready
    );

    modport slave (
        input  sd_data,
        input  sd_valid,
        output sd_ready
    );
endinterface

// File: rtl/tsc_ring_ram.sv
// tsc_ring_ram: DEPTH x DW simple dual-port RAM,
// synchronous write, registered read that holds when re=0.
module tsc_ring_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tsc_pretrig_capture.sv
// tsc_pretrig_capture: edge-triggered ring-buffer capture with
// pre-trigger history, timestamp and valid/ready readout.
module tsc_pretrig_capture
    import tsc_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    parameter int PRE   = 8,
    parameter int TSW   = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           adc_valid,
    input  logic [DW-1:0]  adc_data,
    input  logic [DW-1:0]  thresh,
    input  logic [1:0]     edge_mode,
    input  logic           sbf,
    output logic           trd,
    output logic [TSW-1:0] trigtm,
    output logic           busy,
    output logic           cd,
    tsc_pretrig_capture_if.master sd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE - 2);
    localparam logic [CW-1:0] ACC_LAST  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ISS_END   = CW'(DEPTH);

    state_t          state;
    logic [TSW-1:0]  timer;
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic [AW-1:0]   trig_addr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   iss;
    logic [CW-1:0]   acc;
    logic [DW-1:0]   prev;
    logic [DW-1:0]   thr_q;
    logic [1:0]      mode_q;
    logic            sd_valid;
    logic [DW-1:0]   rdata;

    logic capt;
    logic we;
    logic hit;
    logic re;
    logic accept;

    assign capt = (state == S_PRE) ||
                  (state == S_ARMED) ||
                  (state == S_POST);
    assign we   = capt && adc_valid;
    assign hit  = (state == S_ARMED) && adc_valid &&
                  edge_hit(mode_q, prev >= thr_q,
                           adc_data >= thr_q);

    // Fetch the next word whenever the output slot is empty or draining
    assign accept = sd_valid && sd.sd_ready;
    assign re     = (state == S_SEND) && (iss != ISS_END) &&
                    (!sd_valid || sd.sd_ready);

    assign sd.sd_valid = sd_valid;
    assign sd.sd_data  = rdata;

    tsc_ring_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wp),
        .wdata (adc_data),
        .re    (re),
        .raddr (rp),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            wp        <= '0;
            rp        <= '0;
            trig_addr <= '0;
            cnt       <= '0;
            iss       <= '0;
            acc       <= '0;
            prev      <= '0;
            thr_q     <= '0;
            mode_q    <= '0;
            sd_valid  <= 1'b0;
            trd       <= 1'b0;
            trigtm    <= '0;
            busy      <= 1'b0;
            cd        <= 1'b0;
        end else begin
            timer <= timer + TSW'(1);
            cd    <= 1'b0;
            if (we) begin
                wp   <= wp + AW'(1);
                prev <= adc_data;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_PRE;
                        busy   <= 1'b1;
                        timer  <= '0;
                        thr_q  <= thresh;
                        mode_q <= edge_mode;
                        cnt    <= '0;
                    end
                end
                S_PRE: begin
                    if (adc_valid) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == PRE_LAST) begin
                            state <= S_ARMED;
                            cnt   <= '0;
                        end
                    end
                end
                S_ARMED: begin
                    if (hit) begin
                        state     <= S_POST;
                        trd       <= 1'b1;
                        trigtm    <= timer;
                        trig_addr <= wp;
                    end
                end
                S_POST: begin
                    if (adc_valid) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == POST_LAST) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (sbf) begin
                        state <= S_SEND;
                        rp    <= trig_addr - AW'(PRE);
                        iss   <= '0;
                        acc   <= '0;
                    end
                end
                S_SEND: begin
                    if (re) begin
                        rp       <= rp + AW'(1);
                        iss      <= iss + CW'(1);
                        sd_valid <= 1'b1;
                    end else if (accept) begin
                        sd_valid <= 1'b0;
                    end
                    if (accept) begin
                        acc <= acc + CW'(1);
                        if (acc == ACC_LAST) begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            trd      <= 1'b0;
                            sd_valid <= 1'b0;
                            cd       <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tsc_pretrig_capture.sv
// tb_tsc_pretrig_capture: directed capture/readout scenarios with a
// queue scoreboard checked by an independent readout monitor.
module tb_tsc_pretrig_capture;
    import tsc_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int PRE   = 8;
    localparam int TSW   = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic           adc_valid;
    logic [DW-1:0]  adc_data;
    logic [DW-1:0]  thresh;
    logic [1:0]     edge_mode;
    logic           sbf;
    logic           trd;
    logic [TSW-1:0] trigtm;
    logic           busy;
    logic           cd;

    tsc_pretrig_capture_if #(.DW(DW)) sd_if ();

    tsc_pretrig_capture #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .PRE   (PRE),
        .TSW   (TSW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .thresh    (thresh),
        .edge_mode (edge_mode),
        .sbf       (sbf),
        .trd       (trd),
        .trigtm    (trigtm),
        .busy      (busy),
        .cd        (cd),
        .sd        (sd_if)
    );

    int            n_chk = 0;
    int            n_fail = 0;
    bit            rnd = 0;
    logic [DW-1:0] q[$];
    int            rd_cnt = 0;
    bit            stall = 0;
    bit            cd_due = 0;
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] exp_v;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string nm,
                          input logic [63:0] act,
                          input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sd_if.sd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            sd_if.sd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            rd_cnt = 0;
            stall  = 0;
            cd_due = 0;
        end else begin
            if (cd || cd_due) begin
                chk_eq("cd_pulse", 64'(cd), 64'(cd_due));
            end
            cd_due = 0;
            if (stall) begin
                chk_eq("stall_valid", 64'(sd_if.sd_valid), 64'd1);
                chk_eq("stall_data", 64'(sd_if.sd_data), 64'(last_data));
            end
            if (sd_if.sd_valid && sd_if.sd_ready) begin
                if (q.size() == 0) begin
                    chk_eq("extra_beat", 64'(q.size()), 64'd1);
                end else begin
                    exp_v = q.pop_front();
                    chk_eq("sd_data", 64'(sd_if.sd_data), 64'(exp_v));
                end
                rd_cnt++;
                if (rd_cnt == DEPTH) begin
                    rd_cnt = 0;
                    cd_due = 1;
                end
            end
            stall     = sd_if.sd_valid && !sd_if.sd_ready;
            last_data = sd_if.sd_data;
        end
    end

    task automatic drive(input bit tog, input int i, input int k);
        adc_valid = !tog || (i % 2 == 0);
        adc_data  = adc_valid ? DW'(k) : '1;
    endtask

    task automatic capture(input int base, input int dir,
                           input logic [DW-1:0] th,
                           input logic [1:0] md,
                           input bit tog, input bit extra,
                           input int exp_tm);
        int k;
        int i;
        int nv;
        bit seen;
        thresh    = th;
        edge_mode = md;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
        thresh    = '1;
        edge_mode = 2'b11;
        chk_eq("busy_on_start", 64'(busy), 64'd1);
        k    = base;
        i    = 0;
        seen = 0;
        while (!seen && i < 1000) begin
            drive(tog, i, k);
            start = extra && (i == 12);
            sbf   = start;
            cyc();
            if (adc_valid) k += dir;
            i++;
            seen = trd;
        end
        start = 1'b0;
        sbf   = 1'b0;
        chk_eq("trd_rise", 64'(seen), 64'd1);
        chk_eq("trigtm", 64'(trigtm), 64'(exp_tm));
        nv = 0;
        while (nv < DEPTH - PRE - 1 && i < 2000) begin
            drive(tog, i, k);
            cyc();
            if (adc_valid) begin
                nv++;
                k += dir;
            end
            i++;
        end
        adc_valid = 1'b1;
        adc_data  = 8'h5A;
        repeat (4) cyc();
        adc_valid = 1'b0;
        chk_eq("trd_hold", 64'(trd), 64'd1);
        chk_eq("busy_done", 64'(busy), 64'd1);
    endtask

    task automatic readout(input int first, input int dir,
                           input bit mid_sbf);
        bit got;
        got = 0;
        for (int j = 0; j < DEPTH; j++) begin
            q.push_back(DW'(first + dir * j));
        end
        sbf = 1'b1;
        cyc();
        sbf = 1'b0;
        for (int n = 0; n < 3000 && !got; n++) begin
            sbf = mid_sbf && (n == 10);
            cyc();
            got = cd;
        end
        sbf = 1'b0;
        chk_eq("cd_seen", 64'(got), 64'd1);
        chk_eq("trd_after_cd", 64'(trd), 64'd0);
        chk_eq("busy_after_cd", 64'(busy), 64'd0);
        chk_eq("valid_after_cd", 64'(sd_if.sd_valid), 64'd0);
        chk_eq("queue_empty", 64'(q.size()), 64'd0);
        cyc();
    endtask

    task automatic check_zero(input string tag);
        chk_eq({tag, "_trd"}, 64'(trd), 64'd0);
        chk_eq({tag, "_trigtm"}, 64'(trigtm), 64'd0);
        chk_eq({tag, "_busy"}, 64'(busy), 64'd0);
        chk_eq({tag, "_cd"}, 64'(cd), 64'd0);
        chk_eq({tag, "_valid"}, 64'(sd_if.sd_valid), 64'd0);
        chk_eq({tag, "_data"}, 64'(sd_if.sd_data), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        adc_valid = 1'b0;
        adc_data  = '0;
        thresh    = '0;
        edge_mode = EDGE_RISE;
        sbf       = 1'b0;
        repeat (3) cyc();
        check_zero("reset");
        rst = 1'b1;
        repeat (2) cyc();

        capture(0, 1, 8'd20, EDGE_RISE, 0, 0, 20);
        readout(12, 1, 0);

        capture(100, -1, 8'd50, EDGE_FALL, 0, 0, 51);
        readout(57, -1, 0);

        capture(0, 1, 8'd200, EDGE_RISE, 0, 0, 200);
        readout(192, 1, 0);

        capture(0, 1, 8'd20, EDGE_RISE, 1, 0, 40);
        readout(12, 1, 0);

        rnd = 1;
        capture(0, 1, 8'd20, EDGE_ANY, 0, 0, 20);
        readout(12, 1, 0);
        rnd = 0;

        capture(0, 1, 8'd20, EDGE_RISE, 0, 1, 20);
        readout(12, 1, 1);

        capture(0, 1, 8'd20, EDGE_RISE, 0, 0, 20);
        for (int j = 0; j < DEPTH; j++) q.push_back(DW'(12 + j));
        sbf = 1'b1;
        cyc();
        sbf = 1'b0;
        repeat (12) cyc();
        chk_eq("midsend_valid", 64'(sd_if.sd_valid), 64'd1);
        rst = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        capture(0, 1, 8'd20, EDGE_RISE, 0, 0, 20);
        readout(12, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
